// File: rtl/cp0.sv
// CP0: minimal MIPS coprocessor 0 with SR, Cause, EPC and PRId.
// It raises a combinational flush/redirect request for interrupts and
// exceptions, and records the victim PC, delay-slot flag and cause code.
module cp0 (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic        exc_clr,
    input  logic [5:0]  hw_int,
    output logic        req,
    output logic [31:0] epc_out
);

    localparam logic [4:0]  ADDR_SR    = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE = 5'd13;
    localparam logic [4:0]  ADDR_EPC   = 5'd14;
    localparam logic [4:0]  ADDR_PRID  = 5'd15;
    localparam logic [31:0] PRID_VALUE = 32'h0042_5541;

    // Architectural state; only the implemented fields are stored.
    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q,       epc_d;

    logic        int_req;
    logic        exc_req;
    logic        mtc0_sr;
    logic        mtc0_epc;
    logic [31:0] victim_epc;
    logic [31:0] sr_view;
    logic [31:0] cause_view;

    // A pending request is only recognised outside exception level.
    assign int_req = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (exc_code_in != 5'd0) & ~sr_exl_q;
    // Gated by reset so the pipeline sees no request while held in reset.
    assign req     = reset & (int_req | exc_req);

    // A trap steals the cycle, so any same-cycle mtc0 is dropped.
    assign mtc0_sr  = en & ~req & (cp0_addr == ADDR_SR);
    assign mtc0_epc = en & ~req & (cp0_addr == ADDR_EPC);

    // Delay-slot victims restart at the branch; subtraction wraps mod 2^32.
    assign victim_epc = bd_in ? (vpc - 32'd4) : vpc;

    assign sr_view    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
    assign cause_view = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
    assign epc_out    = epc_q;

    // mfc0 read mux straight off the registers (no write-through).
    always_comb begin
        cp0_out = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_out = sr_view;
            ADDR_CAUSE: cp0_out = cause_view;
            ADDR_EPC:   cp0_out = epc_q;
            ADDR_PRID:  cp0_out = PRID_VALUE;
            default:    cp0_out = 32'd0;
        endcase
    end

    // Next-state: trap entry outranks mtc0; eret outranks an mtc0 of EXL only.
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hw_int;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = bd_in;
            epc_d       = victim_epc;
            cause_exc_d = int_req ? 5'd0 : exc_code_in;
        end else begin
            if (mtc0_sr) begin
                sr_im_d  = cp0_in[15:10];
                sr_exl_d = cp0_in[1];
                sr_ie_d  = cp0_in[0];
            end
            if (mtc0_epc) begin
                epc_d = cp0_in;
            end
            if (exc_clr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: expected register values are queued when
// stimulus is applied and compared against mfc0 reads after the edge.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        exc_clr;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out;

    typedef struct {
        string       nm;
        logic [4:0]  addr;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [31:0] PRID = 32'h0042_5541;

    cp0 dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_in      (cp0_in),
        .cp0_out     (cp0_out),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .exc_clr     (exc_clr),
        .hw_int      (hw_int),
        .req         (req),
        .epc_out     (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; en = 1'b0; cp0_addr = 5'd0; cp0_in = 32'd0; vpc = 32'd0;
        bd_in = 1'b0; exc_code_in = 5'd0; exc_clr = 1'b0; hw_int = 6'b000101;
        #12;
        n_checks++;
        if (req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 0", req); end
        n_checks++;
        if (epc_out !== 32'd0) begin n_errors++; $display("FAIL reset_epc_out: got %h expected 0", epc_out); end
        sb.push_back('{"reset_sr", 5'd12, 32'd0});
        sb.push_back('{"reset_cause", 5'd13, 32'd0});
        sb.push_back('{"reset_epc", 5'd14, 32'd0});
        sb.push_back('{"reset_prid", 5'd15, PRID});
        sb.push_back('{"reset_unmapped", 5'd7, 32'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        hw_int = 6'd0;
        reset = 1'b1;
        tick;
        tick;
    endtask

    task automatic test_exception;
        exc_code_in = 5'd12; vpc = 32'h0000_3010; bd_in = 1'b0;
        #1; n_checks++;
        if (req !== 1'b1) begin n_errors++; $display("FAIL exc_req: got %b expected 1", req); end
        tick;
        exc_code_in = 5'd0;
        #1; n_checks++;
        if (req !== 1'b0) begin n_errors++; $display("FAIL exc_req_after_exl: got %b expected 0", req); end
        n_checks++;
        if (epc_out !== 32'h0000_3010) begin n_errors++; $display("FAIL exc_epc_out: got %h expected 00003010", epc_out); end
        sb.push_back('{"exc_sr", 5'd12, 32'h0000_0002});
        sb.push_back('{"exc_cause", 5'd13, 32'h0000_0030});
        sb.push_back('{"exc_epc", 5'd14, 32'h0000_3010});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        exc_clr = 1'b1;
        tick;
        exc_clr = 1'b0;
        sb.push_back('{"eret_sr", 5'd12, 32'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
    endtask

    task automatic test_delay_slot;
        exc_code_in = 5'd4; vpc = 32'h0000_3024; bd_in = 1'b1;
        #1; n_checks++;
        if (req !== 1'b1) begin n_errors++; $display("FAIL bd_req: got %b expected 1", req); end
        tick;
        exc_code_in = 5'd0; bd_in = 1'b0;
        sb.push_back('{"bd_sr", 5'd12, 32'h0000_0002});
        sb.push_back('{"bd_cause", 5'd13, 32'h8000_0010});
        sb.push_back('{"bd_epc", 5'd14, 32'h0000_3020});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        exc_clr = 1'b1;
        tick;
        exc_clr = 1'b0;
    endtask

    task automatic test_int_priority;
        en = 1'b1; cp0_addr = 5'd12; cp0_in = 32'h0000_0401;
        tick;
        en = 1'b0;
        sb.push_back('{"int_sr_write", 5'd12, 32'h0000_0401});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        hw_int = 6'b000001; exc_code_in = 5'd5; vpc = 32'h0000_4000; bd_in = 1'b0;
        #1; n_checks++;
        if (req !== 1'b1) begin n_errors++; $display("FAIL int_req: got %b expected 1", req); end
        tick;
        exc_code_in = 5'd0;
        #1; n_checks++;
        if (req !== 1'b0) begin n_errors++; $display("FAIL int_req_masked_by_exl: got %b expected 0", req); end
        sb.push_back('{"int_cause", 5'd13, 32'h0000_0400});
        sb.push_back('{"int_sr", 5'd12, 32'h0000_0403});
        sb.push_back('{"int_epc", 5'd14, 32'h0000_4000});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        // eret together with an mtc0 that tries to set EXL: EXL must drop, IM/IE apply
        hw_int = 6'd0;
        exc_clr = 1'b1; en = 1'b1; cp0_addr = 5'd12; cp0_in = 32'h0000_0803;
        tick;
        exc_clr = 1'b0; en = 1'b0;
        sb.push_back('{"eret_vs_mtc0_sr", 5'd12, 32'h0000_0801});
        sb.push_back('{"eret_vs_mtc0_cause", 5'd13, 32'h0000_0000});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        en = 1'b1; cp0_addr = 5'd12; cp0_in = 32'd0;
        tick;
        en = 1'b0;
    endtask

    task automatic test_masked_exl;
        en = 1'b1; cp0_addr = 5'd12; cp0_in = 32'h0000_0002;
        tick;
        en = 1'b0;
        exc_code_in = 5'd10; vpc = 32'h0000_5000;
        #1; n_checks++;
        if (req !== 1'b0) begin n_errors++; $display("FAIL masked_req: got %b expected 0", req); end
        tick;
        sb.push_back('{"masked_epc", 5'd14, 32'h0000_4000});
        sb.push_back('{"masked_sr", 5'd12, 32'h0000_0002});
        sb.push_back('{"masked_cause", 5'd13, 32'h0000_0000});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        exc_clr = 1'b1;
        tick;
        exc_clr = 1'b0;
        #1; n_checks++;
        if (req !== 1'b1) begin n_errors++; $display("FAIL req_after_eret: got %b expected 1", req); end
        sb.push_back('{"eret_sr_cleared", 5'd12, 32'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        tick;
        exc_code_in = 5'd0;
        sb.push_back('{"retake_epc", 5'd14, 32'h0000_5000});
        sb.push_back('{"retake_cause", 5'd13, 32'h0000_0028});
        sb.push_back('{"retake_sr", 5'd12, 32'h0000_0002});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        exc_clr = 1'b1;
        tick;
        exc_clr = 1'b0;
    endtask

    task automatic test_mtc0_conflict;
        exc_code_in = 5'd12; vpc = 32'h0000_6000; bd_in = 1'b0;
        en = 1'b1; cp0_addr = 5'd14; cp0_in = 32'h1234_5678;
        #1; n_checks++;
        if (req !== 1'b1) begin n_errors++; $display("FAIL conflict_req: got %b expected 1", req); end
        tick;
        en = 1'b0; exc_code_in = 5'd0;
        sb.push_back('{"conflict_epc", 5'd14, 32'h0000_6000});
        sb.push_back('{"conflict_cause", 5'd13, 32'h0000_0030});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        exc_clr = 1'b1;
        tick;
        exc_clr = 1'b0;
        en = 1'b1; cp0_addr = 5'd14; cp0_in = 32'h1234_5678;
        #1; n_checks++;
        if (epc_out !== 32'h0000_6000) begin n_errors++; $display("FAIL epc_no_bypass: got %h expected 00006000", epc_out); end
        tick;
        en = 1'b0;
        #1; n_checks++;
        if (epc_out !== 32'h1234_5678) begin n_errors++; $display("FAIL epc_write: got %h expected 12345678", epc_out); end
        en = 1'b1; cp0_addr = 5'd13; cp0_in = 32'hFFFF_FFFF;
        tick;
        cp0_addr = 5'd15;
        tick;
        cp0_addr = 5'd3;
        tick;
        en = 1'b0;
        sb.push_back('{"cause_write_ignored", 5'd13, 32'h0000_0030});
        sb.push_back('{"prid_write_ignored", 5'd15, PRID});
        sb.push_back('{"unmapped_write_ignored", 5'd3, 32'd0});
        sb.push_back('{"sr_untouched", 5'd12, 32'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
    endtask

    task automatic test_wrap;
        exc_code_in = 5'd4; vpc = 32'h0000_0000; bd_in = 1'b1;
        #1; n_checks++;
        if (req !== 1'b1) begin n_errors++; $display("FAIL wrap_req: got %b expected 1", req); end
        tick;
        exc_code_in = 5'd0; bd_in = 1'b0;
        sb.push_back('{"wrap_epc", 5'd14, 32'hFFFF_FFFC});
        sb.push_back('{"wrap_cause", 5'd13, 32'h8000_0010});
        sb.push_back('{"wrap_sr", 5'd12, 32'h0000_0002});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
    endtask

    task automatic test_async_reset;
        // EXL is still set from the previous scenario; make IP nonzero too
        hw_int = 6'b000011;
        tick;
        sb.push_back('{"pre_reset_cause", 5'd13, 32'h8000_0C10});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        exc_code_in = 5'd12;
        reset = 1'b0;
        #1; n_checks++;
        if (req !== 1'b0) begin n_errors++; $display("FAIL async_req: got %b expected 0", req); end
        n_checks++;
        if (epc_out !== 32'd0) begin n_errors++; $display("FAIL async_epc_out: got %h expected 0", epc_out); end
        sb.push_back('{"async_sr", 5'd12, 32'd0});
        sb.push_back('{"async_cause", 5'd13, 32'd0});
        sb.push_back('{"async_epc", 5'd14, 32'd0});
        sb.push_back('{"async_prid", 5'd15, PRID});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
        exc_code_in = 5'd0; hw_int = 6'd0;
        reset = 1'b1;
        tick;
        #1; n_checks++;
        if (req !== 1'b0) begin n_errors++; $display("FAIL post_reset_req: got %b expected 0", req); end
        sb.push_back('{"post_reset_sr", 5'd12, 32'd0});
        sb.push_back('{"post_reset_cause", 5'd13, 32'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); cp0_addr = e.addr; #1; n_checks++;
            if (cp0_out !== e.val) begin n_errors++; $display("FAIL %s: got %h expected %h", e.nm, cp0_out, e.val); end
        end
    endtask

    initial begin
        test_reset;
        test_exception;
        test_delay_slot;
        test_int_priority;
        test_masked_exl;
        test_mtc0_conflict;
        test_wrap;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
